// File: rtl/write_merge_buffer.sv
// Single-line write-coalescing buffer: merges byte-enabled word stores into one
// line and drains it downstream on a tag change or an explicit flush.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_EMPTY | no dirty bytes; any store is accepted, non-zero enables open a line
// S_HOLD  | line open; same-tag stores merge, other-tag store or flush drains
// S_DRAIN | line_write asserted with frozen contents until line_resp
module write_merge_buffer #(
    parameter int WORD_W = 16,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_address,
    input  logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W/8-1:0]   mem_byte_enable,
    input  logic                  flush,
    output logic                  mem_resp,
    output logic                  line_write,
    output logic [ADDR_W-1:0]     line_address,
    output logic [LINE_W-1:0]     line_wdata,
    output logic [LINE_W/8-1:0]   line_byte_mask,
    input  logic                  line_resp,
    output logic                  valid
);

    localparam int BPW      = WORD_W / 8;
    localparam int LBYTES   = LINE_W / 8;
    localparam int WORDS    = LINE_W / WORD_W;
    localparam int OFFSET_W = $clog2(LBYTES);
    localparam int WIDX_W   = $clog2(WORDS);
    localparam int BOFF_W   = $clog2(BPW);
    localparam int TAG_W    = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TAG_W-1:0]    r_tag;
    logic [LINE_W-1:0]   r_data;
    logic [LBYTES-1:0]   r_mask;
    logic                r_resp;

    logic [TAG_W-1:0]    w_tag;
    logic [WIDX_W-1:0]   w_widx;
    logic                w_tag_hit;
    logic                w_req;
    logic                w_any_be;
    logic                w_accept;
    logic                w_merge;
    logic                w_load_tag;
    logic                w_clear;
    logic [LINE_W-1:0]   w_data_mrg;
    logic [LBYTES-1:0]   w_mask_mrg;
    logic                w_unused;

    assign w_tag     = mem_address[ADDR_W-1:OFFSET_W];
    assign w_widx    = mem_address[OFFSET_W-1:BOFF_W];
    assign w_tag_hit = (r_tag == w_tag);
    // The resp cycle still shows the request just accepted, so it is masked out.
    assign w_req     = mem_write & ~r_resp;
    assign w_any_be  = |mem_byte_enable;
    assign w_unused  = &{1'b0, mem_address};

    always_comb begin
        w_data_mrg = r_data;
        w_mask_mrg = r_mask;
        for (int j = 0; j < WORDS; j++) begin
            for (int i = 0; i < BPW; i++) begin
                if (w_widx == WIDX_W'(j) && mem_byte_enable[i]) begin
                    w_data_mrg[(j*BPW+i)*8 +: 8] = mem_wdata[i*8 +: 8];
                    w_mask_mrg[j*BPW+i]          = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_merge     = 1'b0;
        w_load_tag  = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (w_any_be) begin
                        w_merge     = 1'b1;
                        w_load_tag  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_req) begin
                    if (w_tag_hit) begin
                        w_accept = 1'b1;
                        w_merge  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (line_resp) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_EMPTY;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_tag   <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_resp  <= w_accept;
            if (w_clear) begin
                r_tag  <= '0;
                r_data <= '0;
                r_mask <= '0;
            end else if (w_merge) begin
                r_data <= w_data_mrg;
                r_mask <= w_mask_mrg;
                if (w_load_tag) begin
                    r_tag <= w_tag;
                end
            end
        end
    end

    assign mem_resp       = r_resp;
    assign line_write     = (r_state == S_DRAIN);
    assign valid          = (r_state != S_EMPTY);
    assign line_address   = {r_tag, {OFFSET_W{1'b0}}};
    assign line_wdata     = r_data;
    assign line_byte_mask = r_mask;

endmodule

// File: tb/tb_write_merge_buffer.sv
// Bench for write_merge_buffer: table vectors, directed drain/flush/reset
// sequences, a 32/256 instance, and randomized stores against a line model.
module tb_write_merge_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mem_write = 1'b0;
    logic [15:0]  mem_address = '0;
    logic [15:0]  mem_wdata = '0;
    logic [1:0]   mem_byte_enable = '0;
    logic         flush = 1'b0;
    logic         mem_resp;
    logic         line_write;
    logic [15:0]  line_address;
    logic [127:0] line_wdata;
    logic [15:0]  line_byte_mask;
    logic         line_resp = 1'b0;
    logic         valid;

    logic         b_mem_write = 1'b0;
    logic [15:0]  b_mem_address = '0;
    logic [31:0]  b_mem_wdata = '0;
    logic [3:0]   b_mem_byte_enable = '0;
    logic         b_mem_resp;
    logic         b_line_write;
    logic [15:0]  b_line_address;
    logic [255:0] b_line_wdata;
    logic [31:0]  b_line_byte_mask;
    logic         b_valid;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    write_merge_buffer #(.WORD_W(16), .LINE_W(128), .ADDR_W(16)) u_dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .flush(flush),
        .mem_resp(mem_resp), .line_write(line_write), .line_address(line_address),
        .line_wdata(line_wdata), .line_byte_mask(line_byte_mask),
        .line_resp(line_resp), .valid(valid)
    );

    write_merge_buffer #(.WORD_W(32), .LINE_W(256), .ADDR_W(16)) u_dut_wide (
        .clk(clk), .reset(reset), .mem_write(b_mem_write), .mem_address(b_mem_address),
        .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_byte_enable), .flush(1'b0),
        .mem_resp(b_mem_resp), .line_write(b_line_write), .line_address(b_line_address),
        .line_wdata(b_line_wdata), .line_byte_mask(b_line_byte_mask),
        .line_resp(1'b0), .valid(b_valid)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Store from the CPU side: request held until mem_resp, then one idle cycle.
    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                            output int lat);
        mem_address = a;
        mem_wdata = d;
        mem_byte_enable = be;
        mem_write = 1'b1;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (mem_resp) break;
        end
        check("store_resp_seen", mem_resp, 1'b1);
        mem_write = 1'b0;
        @(negedge clk);
        check("resp_pulse_width", mem_resp, 1'b0);
    endtask

    typedef struct {
        logic [15:0]  a;
        logic [15:0]  d;
        logic [1:0]   be;
        logic [15:0]  exp_mask;
        logic [127:0] exp_data;
        logic [15:0]  exp_addr;
    } vec_t;

    typedef struct packed {
        logic [15:0]  a;
        logic [127:0] d;
        logic [15:0]  m;
    } line_t;

    line_t exp_q[$];
    line_t got_q[$];
    bit    stable_q[$];
    bit    auto_resp = 1'b0;

    // Downstream sink: random accept latency, records each drained line.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_resp && line_write && !line_resp) begin
                line_t snap;
                bit    st;
                snap = '{a: line_address, d: line_wdata, m: line_byte_mask};
                st = 1'b1;
                repeat ($urandom_range(0, 4)) begin
                    @(negedge clk);
                    if (!line_write || line_address != snap.a || line_wdata != snap.d ||
                        line_byte_mask != snap.m) st = 1'b0;
                end
                line_resp = 1'b1;
                @(negedge clk);
                line_resp = 1'b0;
                got_q.push_back(snap);
                stable_q.push_back(st);
            end
        end
    end

    logic [7:0]  m_bytes [16];
    logic [15:0] m_mask;
    logic [11:0] m_tag;
    bit          m_held;

    task automatic model_emit();
        line_t l;
        l.a = {m_tag, 4'h0};
        l.m = m_mask;
        for (int b = 0; b < 16; b++) l.d[b*8 +: 8] = m_bytes[b];
        exp_q.push_back(l);
        for (int b = 0; b < 16; b++) m_bytes[b] = 8'h00;
        m_mask = '0;
        m_tag = '0;
        m_held = 1'b0;
    endtask

    task automatic model_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        int w;
        if (m_held && a[15:4] != m_tag) model_emit();
        if (be != 2'b00) begin
            if (!m_held) begin
                m_held = 1'b1;
                m_tag = a[15:4];
            end
            w = int'(a[3:1]);
            for (int i = 0; i < 2; i++) begin
                if (be[i]) begin
                    m_bytes[w*2+i] = d[i*8 +: 8];
                    m_mask[w*2+i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   lat;
        int   cnt;
        bit   ok;
        logic [11:0] tags[3];

        vecs[0] = '{16'h1234, 16'hBEEF, 2'b11, 16'h0030, 128'h0000_0000_0000_0000_0000_BEEF_0000_0000, 16'h1230};
        vecs[1] = '{16'h1236, 16'h00AA, 2'b01, 16'h0070, 128'h0000_0000_0000_0000_00AA_BEEF_0000_0000, 16'h1230};
        vecs[2] = '{16'h1234, 16'h5500, 2'b10, 16'h0070, 128'h0000_0000_0000_0000_00AA_55EF_0000_0000, 16'h1230};
        vecs[3] = '{16'h1230, 16'hCAFE, 2'b11, 16'h0073, 128'h0000_0000_0000_0000_00AA_55EF_0000_CAFE, 16'h1230};
        vecs[4] = '{16'h123F, 16'h1357, 2'b10, 16'h8073, 128'h1300_0000_0000_0000_00AA_55EF_0000_CAFE, 16'h1230};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_line_write", line_write, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_mask", line_byte_mask, 16'h0);
        check("rst_data", line_wdata, 128'h0);
        check("rst_addr", line_address, 16'h0);

        for (int k = 0; k < 5; k++) begin
            do_store(vecs[k].a, vecs[k].d, vecs[k].be, lat);
            check("vec_latency", lat, 1);
            check("vec_mask", line_byte_mask, vecs[k].exp_mask);
            check("vec_data", line_wdata, vecs[k].exp_data);
            check("vec_addr", line_address, vecs[k].exp_addr);
            check("vec_valid", valid, 1'b1);
            check("vec_no_line_write", line_write, 1'b0);
        end

        // Different-tag store forces a drain; the store completes afterwards.
        mem_address = 16'h2000; mem_wdata = 16'h1111; mem_byte_enable = 2'b11; mem_write = 1'b1;
        @(negedge clk);
        check("conflict_lw", line_write, 1'b1);
        check("conflict_no_resp", mem_resp, 1'b0);
        check("conflict_addr", line_address, 16'h1230);
        check("conflict_mask", line_byte_mask, 16'h8073);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!line_write || mem_resp || line_wdata != vecs[4].exp_data || line_byte_mask != 16'h8073) ok = 1'b0;
        end
        check("drain_stable", ok, 1'b1);
        line_resp = 1'b1;
        @(negedge clk);
        line_resp = 1'b0;
        check("drain_done_lw", line_write, 1'b0);
        check("drain_done_valid", valid, 1'b0);
        check("drain_done_no_resp", mem_resp, 1'b0);
        @(negedge clk);
        check("stalled_resp", mem_resp, 1'b1);
        check("stalled_mask", line_byte_mask, 16'h0003);
        check("stalled_addr", line_address, 16'h2000);
        check("stalled_data", line_wdata, 128'h1111);
        mem_write = 1'b0;
        @(negedge clk);
        check("stalled_resp_width", mem_resp, 1'b0);

        // Flush beats a same-tag store; the store lands in a fresh line.
        flush = 1'b1;
        mem_address = 16'h2002; mem_wdata = 16'h2222; mem_byte_enable = 2'b11; mem_write = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_pri_lw", line_write, 1'b1);
        check("flush_pri_no_resp", mem_resp, 1'b0);
        check("flush_pri_mask", line_byte_mask, 16'h0003);
        repeat (2) @(negedge clk);
        check("flush_pri_store_stalled", mem_resp, 1'b0);
        line_resp = 1'b1;
        @(negedge clk);
        line_resp = 1'b0;
        check("flush_pri_lw_drop", line_write, 1'b0);
        @(negedge clk);
        check("flush_pri_resp", mem_resp, 1'b1);
        check("flush_pri_fresh_mask", line_byte_mask, 16'h000C);
        check("flush_pri_fresh_data", line_wdata, 128'h2222_0000);
        mem_write = 1'b0;
        @(negedge clk);

        // Drain the held line, then keep flush high while EMPTY.
        flush = 1'b1;
        @(negedge clk);
        check("flush_hold_lw", line_write, 1'b1);
        line_resp = 1'b1;
        @(negedge clk);
        line_resp = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (line_write || valid) cnt++;
        end
        flush = 1'b0;
        check("flush_empty_idle", cnt, 0);

        do_store(16'h4000, 16'hFFFF, 2'b00, lat);
        check("zero_be_latency", lat, 1);
        check("zero_be_valid", valid, 1'b0);
        check("zero_be_mask", line_byte_mask, 16'h0);

        do_store(16'h3000, 16'hABCD, 2'b11, lat);
        check("pre_rst_valid", valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("pre_rst_lw", line_write, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_drain_lw", line_write, 1'b0);
        check("rst_drain_valid", valid, 1'b0);
        check("rst_drain_mask", line_byte_mask, 16'h0);
        check("rst_drain_data", line_wdata, 128'h0);

        b_mem_address = 16'h001C; b_mem_wdata = 32'hDEADBEEF; b_mem_byte_enable = 4'hF; b_mem_write = 1'b1;
        @(negedge clk);
        check("wide_resp", b_mem_resp, 1'b1);
        b_mem_write = 1'b0;
        check("wide_mask", b_line_byte_mask, 32'hF000_0000);
        check("wide_data_hi", b_line_wdata[255:224], 32'hDEADBEEF);
        check("wide_data_lo", b_line_wdata[223:0], 224'h0);
        check("wide_addr", b_line_address, 16'h0000);
        check("wide_valid", b_valid, 1'b1);
        @(negedge clk);
        check("wide_resp_width", b_mem_resp, 1'b0);

        for (int b = 0; b < 16; b++) m_bytes[b] = 8'h00;
        m_mask = '0;
        m_tag = '0;
        m_held = 1'b0;
        tags[0] = 12'h010; tags[1] = 12'h011; tags[2] = 12'h3FF;
        auto_resp = 1'b1;
        for (int op = 0; op < 150; op++) begin
            if ($urandom_range(0, 9) < 8) begin
                logic [15:0] a;
                logic [15:0] d;
                logic [1:0]  be;
                a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15))};
                d = 16'($urandom);
                be = 2'($urandom_range(0, 3));
                model_store(a, d, be);
                do_store(a, d, be, lat);
                check("rnd_valid", valid, m_held);
                check("rnd_mask", line_byte_mask, m_mask);
                check("rnd_addr", line_address, {m_tag, 4'h0});
            end else begin
                if (m_held) model_emit();
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        end
        if (m_held) model_emit();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cnt = 0;
        while (valid && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("rnd_final_idle", valid, 1'b0);
        repeat (3) @(negedge clk);
        auto_resp = 1'b0;

        check("rnd_line_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check("rnd_line_addr", got_q[k].a, exp_q[k].a);
            check("rnd_line_mask", got_q[k].m, exp_q[k].m);
            check("rnd_line_data", got_q[k].d, exp_q[k].d);
            check("rnd_line_stable", stable_q[k], 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/write_merge_buffer.md
Name: write_merge_buffer

Overview:
- Single-line write-coalescing buffer between the CPU-side store path and the L1/pmem line write port.
- Merges successive word stores, with per-byte enables, into one cache line, tracking a per-byte dirty mask.
- Drains the merged line downstream with a req/resp handshake when a store targets a different line or on explicit flush.
- Generalises word-into-line byte merging to parametrised word/line widths, adding state and handshaking.

Parameters:
- WORD_W, 16, store word width in bits; multiple of 8.
- LINE_W, 128, line width in bits; power-of-two multiple of WORD_W.
- ADDR_W, 16, byte address width.
- Derived (localparam): BPW=WORD_W/8; LBYTES=LINE_W/8; OFFSET_W=log2(LBYTES); WIDX_W=log2(LINE_W/WORD_W).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_write  in  1  store request; held until mem_resp.
- mem_address  in  ADDR_W  store byte address; low log2(BPW) bits ignored (word-aligned).
- mem_wdata  in  WORD_W  store data.
- mem_byte_enable  in  BPW  per-byte write enable.
- flush  in  1  level request to drain a held line.
- mem_resp  out  1  one-cycle pulse, store accepted.
- line_write  out  1  downstream write request.
- line_address  out  ADDR_W  held line tag, offset bits zero.
- line_wdata  out  LINE_W  merged line data.
- line_byte_mask  out  LBYTES  dirty bytes; bit b covers line_wdata[8b+:8].
- line_resp  in  1  downstream accepted line_write.
- valid  out  1  buffer holds at least one dirty byte.

Behaviour:
- Reset: all outputs 0, internal mask/data/tag cleared, state EMPTY. Reset mid-DRAIN aborts: line_write low the next cycle, contents discarded.
- States are EMPTY, HOLD and DRAIN. valid=1 exactly in HOLD and DRAIN. line_write=1 exactly in DRAIN.
- Placement:
  - Word index w = mem_address[OFFSET_W-1:log2(BPW)].
  - Byte i of mem_wdata goes to line byte w*BPW+i when mem_byte_enable[i].
  - Sets mask bit w*BPW+i. Later stores overwrite earlier bytes. Non-enabled bytes are untouched.
- Acceptance rule: a store is accepted in a cycle where mem_write=1, mem_resp=0, and the state/tag condition below holds. mem_resp is registered and goes high the following cycle for exactly 1 cycle. A request present during the resp cycle is never accepted in that cycle.
- EMPTY:
  - Store with any enable set: capture tag = mem_address[ADDR_W-1:OFFSET_W], merge, go HOLD.
  - Store with mem_byte_enable all zero: accepted and acknowledged, no state change.
  - flush: no-op, and no line_write is issued.
- HOLD:
  - flush=1: go DRAIN. flush has priority over a simultaneous store, which stalls.
  - Else store with matching tag: merge and acknowledge, stay HOLD.
  - Else store with different tag: go DRAIN with no acknowledge. The store stalls and its request stays asserted.
- DRAIN:
  - line_write=1. line_address, line_wdata and line_byte_mask are stable until line_resp. No store is accepted, even one with a matching tag.
  - On line_resp=1: clear mask, data and tag, go EMPTY. line_write drops the next cycle.
  - A stalled store is accepted from EMPTY in the cycle after entering EMPTY. It is acknowledged one cycle later.
- line_resp outside DRAIN is ignored. There is no limit on drain latency.
- Outputs line_* are driven from registers (no combinational path from mem_* to line_*).

Test Plan:
- Reset, then store addr 0x1234, data 0xBEEF, be=11 -> mem_resp high exactly 1 cycle later; valid=1; line_byte_mask=0x0030; bytes 4,5 = EF,BE; line_address=0x1230.
- Continue with store 0x1236, data 0x00AA, be=01, then store 0x1234, data 0x5500, be=10 -> mask=0x0070; byte6=AA; byte5=55; byte4 still EF; no line_write.
- Store 0x2000, data 0x1111, be=11 while holding 0x1230:
  - Expect line_write=1, line_address=0x1230, mask=0x0070, no mem_resp.
  - Then line_resp after 3 cycles -> EMPTY; store accepted next cycle with mem_resp one cycle after that; mask=0x0003; line_address=0x2000.
- flush in EMPTY -> line_write never asserts.
- flush and matching-tag store in the same HOLD cycle -> DRAIN first; the store is acknowledged only after line_resp, landing in a fresh line.
- Reset asserted during DRAIN -> line_write=0, valid=0, mask=0 next cycle.
- Zero-enable store in EMPTY -> mem_resp pulse, valid stays 0.
- WORD_W=32, LINE_W=256: store addr 0x001C, be=1111, data 0xDEADBEEF -> mask bits 28..31 set; bytes 28..31 = EF,BE,AD,DE.
